// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its busy scoreboard.
package regfile_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    // MIPS architectural register indices
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // Low bit of port `port` inside a flattened bus of `width`-bit slices.
    function automatic int slice_base(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for delayed (load) writeback, with a registered population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int N_WRITE    = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_WRITE-1:0]            write_effective,
    input  logic [N_WRITE*ADDR_WIDTH-1:0] write_addr,
    input  logic                          reserve_enable,
    input  logic [ADDR_WIDTH-1:0]         reserve_addr,
    output logic [(1<<ADDR_WIDTH)-1:0]    busy,
    output logic [ADDR_WIDTH:0]           busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]    busy_next;
    logic [ADDR_WIDTH:0] count_next;
    logic                reserve_valid;

    assign reserve_valid = reserve_enable &&
                           !(ZERO_REG && (reserve_addr == ADDR_WIDTH'(REG_ZERO)));

    // Clears are applied before the set so a load issued over a completing one stays busy.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < N_WRITE; j++) begin
            if (write_effective[j]) begin
                busy_next[write_addr[slice_base(j, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (reserve_valid) begin
            busy_next[reserve_addr] = 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_next = count_next + (ADDR_WIDTH + 1)'(busy_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with zero-register masking, write bypass and busy scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 2,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_READ*ADDR_WIDTH-1:0]  read_addr,
    output logic [N_READ*DATA_WIDTH-1:0]  read_data,
    output logic [N_READ-1:0]             read_busy,
    input  logic [N_WRITE-1:0]            write_enable,
    input  logic [N_WRITE*ADDR_WIDTH-1:0] write_addr,
    input  logic [N_WRITE*DATA_WIDTH-1:0] write_data,
    input  logic                          reserve_enable,
    input  logic [ADDR_WIDTH-1:0]         reserve_addr,
    output logic [ADDR_WIDTH:0]           busy_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [N_WRITE-1:0]    write_effective;
    logic [DEPTH-1:0]      busy;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  rd_busy;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        write_effective = '0;
        for (int j = 0; j < N_WRITE; j++) begin
            write_effective[j] = write_enable[j] &&
                !(ZERO_REG &&
                  (write_addr[slice_base(j, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(REG_ZERO)));
        end
    end

    // NOTE: the array is reset because a read after reset must return zero; it cannot map onto a RAM macro.
    // NOTE: non-blocking updates in port order, so the last (highest-index) port to the same address wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < N_WRITE; j++) begin
                if (write_effective[j]) begin
                    regs[write_addr[slice_base(j, ADDR_WIDTH) +: ADDR_WIDTH]]
                        <= write_data[slice_base(j, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        rd_addr   = '0;
        wr_addr   = '0;
        rd_value  = '0;
        rd_busy   = 1'b0;
        for (int i = 0; i < N_READ; i++) begin
            rd_addr  = read_addr[slice_base(i, ADDR_WIDTH) +: ADDR_WIDTH];
            rd_value = regs[rd_addr];
            rd_busy  = busy[rd_addr];
            if (BYPASS) begin
                // Ascending scan: a later matching port overrides, giving highest-index priority.
                for (int j = 0; j < N_WRITE; j++) begin
                    wr_addr = write_addr[slice_base(j, ADDR_WIDTH) +: ADDR_WIDTH];
                    if (write_effective[j] && (wr_addr == rd_addr)) begin
                        rd_value = write_data[slice_base(j, DATA_WIDTH) +: DATA_WIDTH];
                        rd_busy  = 1'b0;
                    end
                end
            end
            if (reset || (ZERO_REG && (rd_addr == ADDR_WIDTH'(REG_ZERO)))) begin
                rd_value = '0;
                rd_busy  = 1'b0;
            end
            read_data[slice_base(i, DATA_WIDTH) +: DATA_WIDTH] = rd_value;
            read_busy[i] = rd_busy;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_WRITE    (N_WRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk             (clk),
        .reset           (reset),
        .write_effective (write_effective),
        .write_addr      (write_addr),
        .reserve_enable  (reserve_enable),
        .reserve_addr    (reserve_addr),
        .busy            (busy),
        .busy_count      (busy_count)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: a bypassing and a non-bypassing 4R/3W register file share stimulus against one reference model.
module tb_register_file_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int NW    = 3;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [NR*DW-1:0] rd_byp;
        logic [NR*DW-1:0] rd_nob;
        logic [NR-1:0]    rb_byp;
        logic [NR-1:0]    rb_nob;
        logic [AW:0]      cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra [NR];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    logic [NW-1:0] we;
    logic          res_en;
    logic [AW-1:0] res_addr;

    logic [NR*AW-1:0] read_addr_bus;
    logic [NW*AW-1:0] write_addr_bus;
    logic [NW*DW-1:0] write_data_bus;

    logic [NR*DW-1:0] rd_b, rd_n;
    logic [NR-1:0]    rb_b, rb_n;
    logic [AW:0]      cnt_b, cnt_n;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    assign read_addr_bus  = {ra[3], ra[2], ra[1], ra[0]};
    assign write_addr_bus = {wa[2], wa[1], wa[0]};
    assign write_data_bus = {wd[2], wd[1], wd[0]};

    always #5 clk = ~clk;

    register_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR), .N_WRITE(NW),
        .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_byp (
        .clk(clk), .reset(rst),
        .read_addr(read_addr_bus), .read_data(rd_b), .read_busy(rb_b),
        .write_enable(we), .write_addr(write_addr_bus), .write_data(write_data_bus),
        .reserve_enable(res_en), .reserve_addr(res_addr), .busy_count(cnt_b)
    );

    register_file_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_READ(NR), .N_WRITE(NW),
        .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut_nob (
        .clk(clk), .reset(rst),
        .read_addr(read_addr_bus), .read_data(rd_n), .read_busy(rb_n),
        .write_enable(we), .write_addr(write_addr_bus), .write_data(write_data_bus),
        .reserve_enable(res_en), .reserve_addr(res_addr), .busy_count(cnt_n)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        for (int i = 0; i < NR; i++) ra[i] = '0;
        for (int j = 0; j < NW; j++) begin
            wa[j] = '0;
            wd[j] = '0;
        end
        we       = '0;
        res_en   = 1'b0;
        res_addr = '0;
    endtask

    // Predict this cycle's outputs from the model, queue them, apply the edge to the model, advance.
    task automatic commit();
        exp_t          e;
        logic [DW-1:0] d_b, d_n;
        logic          b_b, b_n;
        int            cnt;
        e = '0;
        for (int i = 0; i < NR; i++) begin
            d_n = m_regs[ra[i]];
            b_n = m_busy[ra[i]];
            d_b = d_n;
            b_b = b_n;
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j] != 0 && wa[j] == ra[i]) begin
                    d_b = wd[j];
                    b_b = 1'b0;
                end
            end
            if (rst || ra[i] == 0) begin
                d_b = '0; d_n = '0; b_b = 1'b0; b_n = 1'b0;
            end
            e.rd_byp[i*DW +: DW] = d_b;
            e.rd_nob[i*DW +: DW] = d_n;
            e.rb_byp[i] = b_b;
            e.rb_nob[i] = b_n;
        end
        cnt = 0;
        for (int k = 0; k < DEPTH; k++) cnt += int'(m_busy[k]);
        e.cnt = (AW + 1)'(cnt);
        q.push_back(e);

        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j] != 0) begin
                    m_regs[wa[j]] = wd[j];
                    m_busy[wa[j]] = 1'b0;
                end
            end
            if (res_en && res_addr != 0) m_busy[res_addr] = 1'b1;
        end
        @(posedge clk);
        #2;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rdata_bypass",   rd_b,  e.rd_byp);
            check("rdata_nobypass", rd_n,  e.rd_nob);
            check("rbusy_bypass",   rb_b,  e.rb_byp);
            check("rbusy_nobypass", rb_n,  e.rb_nob);
            check("count_bypass",   cnt_b, e.cnt);
            check("count_nobypass", cnt_n, e.cnt);
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #2;
        commit();
        commit();
        rst = 1'b0;

        for (int k = 0; k < DEPTH; k += NR) begin
            for (int i = 0; i < NR; i++) ra[i] = AW'(k + i);
            #1;
            check("reset_rdata", rd_b | rd_n, '0);
            check("reset_rbusy", {rb_b, rb_n}, '0);
            check("reset_count", cnt_n, '0);
            commit();
        end

        rst = 1'b1; we = 3'b001; wa[0] = 5'd5; wd[0] = 32'h0000_DEAD;
        commit();
        rst = 1'b0; set_idle(); ra[0] = 5'd5;
        #1; check("r5_write_under_reset", rd_n[31:0], 32'h0);
        commit();

        set_idle(); we = 3'b011;
        wa[0] = 5'd3; wd[0] = 32'h1111_1111;
        wa[1] = 5'd3; wd[1] = 32'h2222_2222;
        ra[0] = 5'd3;
        #1; check("collision_bypass", rd_b[31:0], 32'h2222_2222);
        commit();
        set_idle(); ra[0] = 5'd3;
        #1; check("collision_stored", rd_n[31:0], 32'h2222_2222);
        commit();

        set_idle(); we = 3'b011;
        wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
        wa[1] = 5'd7; wd[1] = 32'h0000_0007;
        ra[0] = 5'd0; ra[1] = 5'd7;
        #1;
        check("r0_bypass_masked", rd_b[31:0], 32'h0);
        check("r7_bypass", rd_b[63:32], 32'h7);
        commit();
        set_idle(); ra[0] = 5'd0; ra[1] = 5'd7;
        #1;
        check("r0_stored_zero", rd_n[31:0], 32'h0);
        check("r7_stored", rd_n[63:32], 32'h7);
        commit();

        set_idle(); we = 3'b001; wa[0] = 5'd9; wd[0] = 32'hCAFE_BABE; ra[0] = 5'd9;
        #1;
        check("bypass_same_cycle", rd_b[31:0], 32'hCAFE_BABE);
        check("nobypass_old_value", rd_n[31:0], 32'h0);
        commit();
        set_idle(); ra[0] = 5'd9;
        #1; check("nobypass_next_cycle", rd_n[31:0], 32'hCAFE_BABE);
        commit();

        set_idle(); res_en = 1'b1; res_addr = 5'd12;
        commit();
        set_idle(); ra[0] = 5'd12;
        #1;
        check("r12_busy", rb_n[0], 1'b1);
        check("count_one", cnt_n, 1);
        commit();
        set_idle(); we = 3'b001; wa[0] = 5'd12; wd[0] = 32'h55; ra[0] = 5'd12;
        #1;
        check("busy_masked_by_bypass", rb_b[0], 1'b0);
        check("busy_unmasked_nobypass", rb_n[0], 1'b1);
        commit();
        set_idle(); ra[0] = 5'd12;
        #1;
        check("r12_cleared", rb_n[0], 1'b0);
        check("count_zero", cnt_n, 0);
        commit();
        set_idle(); res_en = 1'b1; res_addr = 5'd12; we = 3'b001; wa[0] = 5'd12; wd[0] = 32'h66;
        commit();
        set_idle(); ra[0] = 5'd12;
        #1; check("reserve_beats_write", rb_n[0], 1'b1);
        commit();
        set_idle(); we = 3'b001; wa[0] = 5'd12; wd[0] = 32'h77;
        commit();

        set_idle(); res_en = 1'b1; res_addr = 5'd0;
        commit();
        set_idle(); ra[0] = 5'd0;
        #1;
        check("r0_never_busy", rb_n[0], 1'b0);
        check("count_r0_reserve", cnt_n, 0);
        commit();
        set_idle(); res_en = 1'b1; res_addr = 5'd1;
        commit();
        res_addr = 5'd2;
        commit();
        res_addr = AW'(REG_RA);
        commit();
        set_idle(); ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = AW'(REG_RA);
        #1;
        check("count_three", cnt_n, 3);
        check("three_busy", rb_n[2:0], 3'b111);
        commit();
        rst = 1'b1;
        #1; check("reset_masks_busy", {rb_b, rb_n}, '0);
        commit();
        rst = 1'b0;
        #1;
        check("count_after_reset", cnt_n, 0);
        check("busy_after_reset", rb_n, '0);
        commit();

        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NR; i++) ra[i] = pick();
            for (int j = 0; j < NW; j++) begin
                we[j] = ($urandom_range(0, 1) == 1);
                wa[j] = pick();
                wd[j] = $urandom();
            end
            res_en   = ($urandom_range(0, 2) == 0);
            res_addr = pick();
            commit();
        end

        rst = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
